cordic_iter_ctrl: RTL and testbench

//  Sequential rotation-mode CORDIC engine controller for the 16-bit datapath. Accepts (X,Y,Z) via a

---
 rtl/cordic_pkg.sv | 16 +
 rtl/cordic_iter_ctrl_ashr.sv | 11 +
 rtl/cordic_iter_ctrl.sv | 94 +++++++++
 tb/tb_cordic_iter_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants, arctan table and FSM encoding for the sequential CORDIC controller.
//   W          datapath width (16, signed two's complement)
//   FRAC       Q2.13 fractional bits
//   ATAN_LUT   atan(2^-i) in Q2.13 radians, i = 0..15
//   state_t    IDLE, LOAD, ITER, COMP, DONE
//   GAIN_SH    shift set approximating K ~ 0.60742 (used only when CORDIC_GAIN_COMP_EN is defined)
package cordic_pkg;
    localparam int W = 16;
    localparam int FRAC = 13;
    localparam logic signed [15:0] ATAN_LUT [16] = '{
        16'sd6434, 16'sd3798, 16'sd2007, 16'sd1019, 16'sd511, 16'sd256, 16'sd128, 16'sd64,
        16'sd32, 16'sd16, 16'sd8, 16'sd4, 16'sd2, 16'sd1, 16'sd0, 16'sd0
    };
    typedef enum logic [2:0] {IDLE, LOAD, ITER, COMP, DONE} state_t;
    localparam int GAIN_SH [4] = '{1, 3, 6, 9};
endpackage

// File: rtl/cordic_iter_ctrl_ashr.sv
// cordic_ashr16: 16-bit arithmetic right shifter.
//   a   in  16  signed operand
//   sh  in  4   shift amount 0..15
//   y   out 16  a >>> sh (sign-filled)
module cordic_ashr16 (
    input  logic signed [15:0] a,
    input  logic        [3:0]  sh,
    output logic signed [15:0] y
);
    assign y = a >>> sh;
endmodule

// File: rtl/cordic_iter_ctrl.sv
// cordic_iter_ctrl: sequential rotation-mode CORDIC controller, one micro-rotation per clock.
//   clk, rst_n (async, active low)
//   in_valid/in_ready, x_in/y_in/z_in   operand handshake (Q2.13, z in radians)
//   out_valid/out_ready, x_out/y_out/z_out   result handshake, held until accepted
//   busy   high in LOAD/ITER/COMP/DONE
//   CORDIC_GAIN_COMP_EN defined: adds a COMP state scaling x,y by K ~ 0.60742 before DONE.
module cordic_iter_ctrl
    import cordic_pkg::*;
#(
    parameter int ITERS = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] x_in,
    input  logic signed [W-1:0] y_in,
    input  logic signed [W-1:0] z_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] x_out,
    output logic signed [W-1:0] y_out,
    output logic signed [W-1:0] z_out,
    output logic                busy
);
    state_t state, state_nx;
    logic [4:0] iter;
    logic signed [W-1:0] x, y, z, xs, ys, at;
    logic d;

    cordic_ashr16 u_shx (.a(x), .sh(iter[3:0]), .y(xs));
    cordic_ashr16 u_shy (.a(y), .sh(iter[3:0]), .y(ys));

    assign at = ATAN_LUT[iter[3:0]];
    // z == 0 rotates in the positive direction
    assign d = ~z[W-1];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = in_valid ? LOAD : IDLE;
            LOAD: state_nx = ITER;
`ifdef CORDIC_GAIN_COMP_EN
            ITER: state_nx = (iter == 5'(ITERS - 1)) ? COMP : ITER;
            COMP: state_nx = DONE;
`else
            ITER: state_nx = (iter == 5'(ITERS - 1)) ? DONE : ITER;
`endif
            DONE: state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Operands are latched on the accepting edge so the source may move on after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            iter <= '0;
            x <= '0;
            y <= '0;
            z <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (in_valid) begin
                    x <= x_in;
                    y <= y_in;
                    z <= z_in;
                end
                LOAD: iter <= '0;
                ITER: begin
                    x <= d ? x - ys : x + ys;
                    y <= d ? y + xs : y - xs;
                    z <= d ? z - at : z + at;
                    iter <= iter + 5'd1;
                end
`ifdef CORDIC_GAIN_COMP_EN
                COMP: begin
                    x <= (x >>> GAIN_SH[0]) + (x >>> GAIN_SH[1]) - (x >>> GAIN_SH[2]) - (x >>> GAIN_SH[3]);
                    y <= (y >>> GAIN_SH[0]) + (y >>> GAIN_SH[1]) - (y >>> GAIN_SH[2]) - (y >>> GAIN_SH[3]);
                end
`endif
                default: ;
            endcase
        end
    end

    assign in_ready = (state == IDLE);
    assign busy = (state != IDLE);
    assign out_valid = (state == DONE);
    assign x_out = x;
    assign y_out = y;
    assign z_out = z;
endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// tb_cordic_iter_ctrl: directed vector bench for cordic_iter_ctrl (ITERS=14 and ITERS=1 instances).
module tb_cordic_iter_ctrl;
    typedef struct {
        int x, y, z, ex, ey, tx, ty;
    } vec_t;

`ifdef CORDIC_GAIN_COMP_EN
    localparam int COMP_LAT = 1;
`else
    localparam int COMP_LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid [2];
    logic in_ready [2];
    logic out_valid [2];
    logic out_ready [2];
    logic busy [2];
    logic signed [15:0] x_in [2];
    logic signed [15:0] y_in [2];
    logic signed [15:0] z_in [2];
    logic signed [15:0] x_out [2];
    logic signed [15:0] y_out [2];
    logic signed [15:0] z_out [2];

    int pass_cnt = 0;
    int tot_cnt = 0;

    always #5 clk = ~clk;

    cordic_iter_ctrl #(.ITERS(14)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .x_in(x_in[0]), .y_in(y_in[0]), .z_in(z_in[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .x_out(x_out[0]), .y_out(y_out[0]), .z_out(z_out[0]),
        .busy(busy[0])
    );

    cordic_iter_ctrl #(.ITERS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .x_in(x_in[1]), .y_in(y_in[1]), .z_in(z_in[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .x_out(x_out[1]), .y_out(y_out[1]), .z_out(z_out[1]),
        .busy(busy[1])
    );

    task automatic chk(input string name, input int act, input int exp, input int tol);
        int diff;
        diff = act - exp;
        if (diff < 0) diff = -diff;
        tot_cnt++;
        if (diff <= tol) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
    endtask

    // Handshake one operand, then count cycles until out_valid (cycle index: handshake cycle = 0).
    task automatic start_op(input int u, input int x, input int y, input int z, output int lat);
        @(negedge clk);
        x_in[u] = 16'(x);
        y_in[u] = 16'(y);
        z_in[u] = 16'(z);
        in_valid[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[u] = 1'b0;
        x_in[u] = 16'sd0;
        y_in[u] = 16'sd0;
        z_in[u] = 16'sd0;
        lat = 1;
        while (!out_valid[u] && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    vec_t vt [5];

    initial begin
        int lat, hx, hy, hz;
        bit stable;
        for (int u = 0; u < 2; u++) begin
            in_valid[u] = 1'b0;
            out_ready[u] = 1'b1;
            x_in[u] = 16'sd0;
            y_in[u] = 16'sd0;
            z_in[u] = 16'sd0;
        end
`ifdef CORDIC_GAIN_COMP_EN
        vt[0] = '{8192, 0, 6434, 5793, 5793, 6, 6};
        vt[1] = '{8192, 0, -12868, 0, -8192, 6, 8};
        vt[2] = '{8192, 0, 0, 8192, 0, 10, 10};
        vt[3] = '{8192, 0, 12868, 0, 8192, 8, 8};
        vt[4] = '{0, 8192, -6434, 5793, 5793, 8, 8};
`else
        vt[0] = '{8192, 0, 6434, 9540, 9540, 6, 6};
        vt[1] = '{8192, 0, -12868, 0, -13490, 6, 8};
        vt[2] = '{8192, 0, 0, 13491, 0, 10, 10};
        vt[3] = '{8192, 0, 12868, 0, 13490, 8, 8};
        vt[4] = '{0, 8192, -6434, 9540, 9540, 8, 8};
`endif
        repeat (2) @(negedge clk);
        chk("reset_in_ready", int'(in_ready[0]), 1, 0);
        chk("reset_out_valid", int'(out_valid[0]), 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_busy", int'(busy[0]), 0, 0);
        chk("post_reset_x_out", int'(x_out[0]), 0, 0);

        for (int i = 0; i < 5; i++) begin
            start_op(0, vt[i].x, vt[i].y, vt[i].z, lat);
            chk($sformatf("v%0d_latency", i), lat, 16 + COMP_LAT, 0);
            chk($sformatf("v%0d_x_out", i), int'(x_out[0]), vt[i].ex, vt[i].tx);
            chk($sformatf("v%0d_y_out", i), int'(y_out[0]), vt[i].ey, vt[i].ty);
            chk($sformatf("v%0d_z_resid", i), int'(z_out[0]), 0, 8);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_release_valid", i), int'(out_valid[0]), 0, 0);
            chk($sformatf("v%0d_release_ready", i), int'(in_ready[0]), 1, 0);
        end

        // ITERS=1: exact single micro-rotation and minimal latency
        start_op(1, 8192, 0, 100, lat);
        chk("iters1_latency", lat, 3 + COMP_LAT, 0);
`ifdef CORDIC_GAIN_COMP_EN
        chk("iters1_x_out", int'(x_out[1]), 4976, 0);
        chk("iters1_y_out", int'(y_out[1]), 4976, 0);
`else
        chk("iters1_x_out", int'(x_out[1]), 8192, 0);
        chk("iters1_y_out", int'(y_out[1]), 8192, 0);
`endif
        chk("iters1_z_out", int'(z_out[1]), 100 - 6434, 0);

        // Backpressure: result held, new operands ignored
        out_ready[0] = 1'b0;
        start_op(0, vt[0].x, vt[0].y, vt[0].z, lat);
        chk("bp_latency", lat, 16 + COMP_LAT, 0);
        hx = int'(x_out[0]);
        hy = int'(y_out[0]);
        hz = int'(z_out[0]);
        chk("bp_x_out", hx, vt[0].ex, vt[0].tx);
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid[0] = c[0];
            x_in[0] = 16'sd1000;
            z_in[0] = -16'sd3000;
            @(posedge clk);
            @(negedge clk);
            if (!out_valid[0] || in_ready[0] || int'(x_out[0]) != hx ||
                int'(y_out[0]) != hy || int'(z_out[0]) != hz) stable = 1'b0;
        end
        in_valid[0] = 1'b0;
        chk("bp_hold_stable", int'(stable), 1, 0);
        chk("bp_hold_in_ready", int'(in_ready[0]), 0, 0);
        out_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_exit_valid", int'(out_valid[0]), 0, 0);
        chk("bp_exit_in_ready", int'(in_ready[0]), 1, 0);
        @(posedge clk);
        @(negedge clk);
        chk("bp_no_phantom_busy", int'(busy[0]), 0, 0);

        // Async reset mid-ITER (iter=5 during cycle index 7)
        start_op(0, 8192, 0, 6434, lat);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        begin
            @(negedge clk);
            x_in[0] = 16'sd8192;
            z_in[0] = 16'sd6434;
            in_valid[0] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid[0] = 1'b0;
            repeat (6) @(negedge clk);
            chk("mid_busy", int'(busy[0]), 1, 0);
            #2 rst_n = 1'b0;
            #1;
            chk("arst_out_valid", int'(out_valid[0]), 0, 0);
            chk("arst_in_ready", int'(in_ready[0]), 1, 0);
            chk("arst_busy", int'(busy[0]), 0, 0);
            chk("arst_x_out", int'(x_out[0]), 0, 0);
            chk("arst_y_out", int'(y_out[0]), 0, 0);
            chk("arst_z_out", int'(z_out[0]), 0, 0);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (20) @(negedge clk);
            chk("arst_no_output", int'(out_valid[0]), 0, 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
